reg_file: RTL and testbench

- General-purpose register file for the 16-bit CPU datapath.
- Sits directly upstream of the datapath's 16-bit 2:1 operand select mux.
- Read port A drives the mux's X input; read port B feeds the ALU operand path.
- One synchronous write port; two asynchronous read ports with write-first bypass, so the mux sees freshly written data in the same cycle.

---
 rtl/reg_file.sv | 87 ++++++++
 tb/tb_reg_file.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file
//  Purpose  : General-purpose register file for the 16-bit CPU datapath.
//             One synchronous write port and two asynchronous read ports with
//             write-first bypass, so a value being written this cycle is
//             already visible on the read ports before the clock edge.
//  Ports    : Clock   - single clock, rising-edge active
//             Resetn  - synchronous active-low reset; clears all registers
//             WR      - write enable
//             WAddr   - write address
//             WData   - write data
//             RAddrA  - read address, port A (feeds operand mux X input)
//             RAddrB  - read address, port B (feeds ALU operand path)
//             RDataA  - read data, port A
//             RDataB  - read data, port B
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int ZERO_R0 = 0
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              WR,
  input  logic [ADDR_W-1:0] WAddr,
  input  logic [DATA_W-1:0] WData,
  input  logic [ADDR_W-1:0] RAddrA,
  input  logic [ADDR_W-1:0] RAddrB,
  output logic [DATA_W-1:0] RDataA,
  output logic [DATA_W-1:0] RDataB
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit C_ZERO_R0 = (ZERO_R0 != 0);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_wr_suppress;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_rdata_a;
  logic [DATA_W-1:0] w_rdata_b;

  // A write is effective only out of reset and when it does not target a
  // hardwired-zero r0. The same qualified enable drives storage and bypass,
  // so the bypassed value is always exactly what storage will hold.
  assign w_wr_suppress = C_ZERO_R0 && (WAddr == '0);
  assign w_wr_en       = Resetn && WR && !w_wr_suppress;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[WAddr] <= WData;
    end
  end

  // Read priority (lowest to highest): storage, bypass, forced zero.
  // Forced zero covers both the reset-low window and the hardwired r0.
  always_comb begin
    w_rdata_a = r_mem[RAddrA];
    if (w_wr_en && (RAddrA == WAddr)) begin
      w_rdata_a = WData;
    end
    if (!Resetn || (C_ZERO_R0 && (RAddrA == '0))) begin
      w_rdata_a = '0;
    end
  end

  always_comb begin
    w_rdata_b = r_mem[RAddrB];
    if (w_wr_en && (RAddrB == WAddr)) begin
      w_rdata_b = WData;
    end
    if (!Resetn || (C_ZERO_R0 && (RAddrB == '0))) begin
      w_rdata_b = '0;
    end
  end

  assign RDataA = w_rdata_a;
  assign RDataB = w_rdata_b;

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file
//  Purpose  : Self-checking bench for reg_file. Two instances are driven in
//             parallel: one with r0 as a normal register, one with r0
//             hardwired to zero. Expected read data comes from an array
//             model of the architectural state plus the write-first rule.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file;

  logic        Clock;
  logic        Resetn;
  logic        WR;
  logic [3:0]  WAddr;
  logic [15:0] WData;
  logic [3:0]  RAddrA;
  logic [3:0]  RAddrB;
  logic [15:0] RDataA0, RDataB0;
  logic [15:0] RDataA1, RDataB1;

  int vectors    = 0;
  int miscompares = 0;

  // Architectural state of each build: index 0 = normal r0, 1 = zero r0.
  logic [15:0] model [2][16];

  reg_file #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(0)) u_dut0 (
    .Clock (Clock), .Resetn(Resetn), .WR(WR), .WAddr(WAddr), .WData(WData),
    .RAddrA(RAddrA), .RAddrB(RAddrB), .RDataA(RDataA0), .RDataB(RDataB0)
  );

  reg_file #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1)) u_dut1 (
    .Clock (Clock), .Resetn(Resetn), .WR(WR), .WAddr(WAddr), .WData(WData),
    .RAddrA(RAddrA), .RAddrB(RAddrB), .RDataA(RDataA1), .RDataB(RDataB1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Does a write this cycle land in build b?
  function automatic bit write_lands(int b);
    return Resetn && WR && !(b == 1 && WAddr == 4'd0);
  endfunction

  // What read address ra of build b should show right now.
  function automatic logic [15:0] expect_rd(int b, logic [3:0] ra);
    if (!Resetn)                   return 16'h0000;
    if (b == 1 && ra == 4'd0)      return 16'h0000;
    if (write_lands(b) && ra == WAddr) return WData;
    return model[b][ra];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic wr, input logic [3:0] wa,
                       input logic [15:0] wd, input logic [3:0] ra, input logic [3:0] rb);
    Resetn = rst_n; WR = wr; WAddr = wa; WData = wd; RAddrA = ra; RAddrB = rb;
    #2;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_A0"}, RDataA0, expect_rd(0, RAddrA));
    chk({tag, "_B0"}, RDataB0, expect_rd(0, RAddrB));
    chk({tag, "_A1"}, RDataA1, expect_rd(1, RAddrA));
    chk({tag, "_B1"}, RDataB1, expect_rd(1, RAddrB));
  endtask

  // Advance one rising edge and retire this cycle's effect into the model.
  task automatic tick();
    bit land0, land1;
    land0 = write_lands(0);
    land1 = write_lands(1);
    @(posedge Clock);
    for (int b = 0; b < 2; b++) begin
      if (!Resetn) begin
        for (int i = 0; i < 16; i++) model[b][i] = 16'h0000;
      end
    end
    if (Resetn && land0) model[0][WAddr] = WData;
    if (Resetn && land1) model[1][WAddr] = WData;
    #1;
  endtask

  task automatic step(input string tag, input logic rst_n, input logic wr,
                      input logic [3:0] wa, input logic [15:0] wd,
                      input logic [3:0] ra, input logic [3:0] rb);
    drive(rst_n, wr, wa, wd, ra, rb);
    check_all(tag);
    tick();
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 16; i++) model[b][i] = 16'h0000;
    Resetn = 1'b0; WR = 1'b0; WAddr = '0; WData = '0; RAddrA = '0; RAddrB = '0;
    @(posedge Clock); #1;

    // Initial reset, then preload r3.
    step("init_rst", 1'b0, 1'b0, 4'd0, 16'h0000, 4'd3, 4'd0);
    step("preload", 1'b1, 1'b1, 4'd3, 16'hBEEF, 4'd3, 4'd3);
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'd3, 4'd3);
    chk("preload_r3", RDataA0, 16'hBEEF);

    // Reset with a coincident write: outputs zero in the low cycle, write lost.
    drive(1'b0, 1'b1, 4'd3, 16'h1234, 4'd3, 4'd3);
    check_all("rst_wr");
    chk("rst_low_A", RDataA0, 16'h0000);
    tick();
    for (int i = 0; i < 16; i++)
      step("post_rst", 1'b1, 1'b0, 4'(i), 16'hFFFF, 4'(i), 4'(15 - i));
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'd3, 4'd3);
    chk("post_rst_r3", RDataA0, 16'h0000);

    // Write/readback on consecutive edges.
    step("wr5", 1'b1, 1'b1, 4'd5, 16'hA5A5, 4'd5, 4'd10);
    step("wr10", 1'b1, 1'b1, 4'd10, 16'h5A5A, 4'd5, 4'd10);
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'd5, 4'd10);
    chk("rb_r5", RDataA0, 16'hA5A5);
    chk("rb_r10", RDataB0, 16'h5A5A);
    for (int i = 0; i < 16; i++)
      step("rb_all", 1'b1, 1'b0, 4'd0, 16'h0000, 4'(i), 4'(i ^ 1));

    // Bypass: both ports on the address being written.
    step("bp_pre", 1'b1, 1'b1, 4'd7, 16'h0001, 4'd7, 4'd7);
    drive(1'b1, 1'b1, 4'd7, 16'hFFFF, 4'd7, 4'd7);
    check_all("bp");
    chk("bp_A", RDataA0, 16'hFFFF);
    chk("bp_B", RDataB0, 16'hFFFF);
    tick();
    drive(1'b1, 1'b0, 4'd7, 16'h0000, 4'd7, 4'd7);
    check_all("bp_post");
    chk("bp_post_A", RDataA1, 16'hFFFF);
    tick();

    // No-write hold on r2 while address/data toggle.
    for (int c = 0; c < 5; c++)
      step("hold", 1'b1, 1'b0, 4'd2, (c % 2 == 0) ? 16'h7777 : 16'h8888, 4'd2, 4'd2);
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'd2, 4'd2);
    chk("hold_r2", RDataA0, 16'h0000);

    // r0 write: bypassed and stored on the normal build, zero on the other.
    drive(1'b1, 1'b1, 4'd0, 16'h1111, 4'd0, 4'd0);
    check_all("r0_wr");
    chk("r0_bp_n", RDataA0, 16'h1111);
    chk("r0_bp_z", RDataA1, 16'h0000);
    tick();
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'd0, 4'd0);
    check_all("r0_rd");
    chk("r0_st_n", RDataA0, 16'h1111);
    chk("r0_st_z", RDataA1, 16'h0000);
    tick();

    // Sweep: ri = i*0x0101, then read (i, 15-i).
    for (int i = 0; i < 16; i++)
      step("sweep_wr", 1'b1, 1'b1, 4'(i), 16'(i * 16'h0101), 4'(15 - i), 4'(i));
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'(i), 4'(15 - i));
      check_all("sweep_rd");
      if (i != 0) chk("sweep_lit", RDataA1, 16'(i * 16'h0101));
      tick();
    end

    // Back-to-back writes to one address: last write wins.
    step("b2b_1", 1'b1, 1'b1, 4'd9, 16'h1357, 4'd9, 4'd8);
    step("b2b_2", 1'b1, 1'b1, 4'd9, 16'h2468, 4'd9, 4'd8);
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'd9, 4'd8);
    chk("b2b_last", RDataA0, 16'h2468);
    tick();

    // Randomized traffic including occasional reset.
    for (int n = 0; n < 400; n++) begin
      step("rand",
           ($urandom_range(0, 24) != 0),
           1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)),
           16'($urandom),
           4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
